// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialization sequencer (WAIT/PRECHARGE/REFRESH/LOAD MODE)
// followed by a free-running refresh-interval timer with a req/ack handshake.
module sdram_init_ctrl #(
    parameter int unsigned T_POWERUP    = 10600,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 4,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned NUM_REF      = 8,
    parameter logic [12:0] MODE_REG     = 13'h032,
    parameter int unsigned REF_INTERVAL = 400
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        ref_ack,
    output logic        sdr_cke,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_miss
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NUM_W = 4;

    localparam logic [CNT_W-1:0] T_POWERUP_C = CNT_W'(T_POWERUP);
    localparam logic [CNT_W-1:0] T_RP_C      = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] T_RFC_C     = CNT_W'(T_RFC);
    localparam logic [CNT_W-1:0] T_MRD_C     = CNT_W'(T_MRD);
    localparam logic [CNT_W-1:0] REF_LAST_C  = CNT_W'(REF_INTERVAL - 1);
    localparam logic [NUM_W-1:0] NUM_REF_C   = NUM_W'(NUM_REF);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    typedef enum logic [2:0] {
        S_WAIT,
        S_PRE,
        S_REF,
        S_LMR,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] ref_cnt, ref_cnt_d;
    logic [NUM_W-1:0] ref_num, ref_num_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             cke_q, cke_d;
    logic [1:0]       ba_q, ba_d;
    logic [12:0]      addr_q, addr_d;
    logic             done_q, done_d;
    logic             req_q, req_d;
    logic             miss_q, miss_d;

    // State, counters and every output are registered here.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_WAIT;
            cnt     <= '0;
            ref_cnt <= '0;
            ref_num <= '0;
            cmd_q   <= CMD_INHIBIT;
            cke_q   <= 1'b0;
            ba_q    <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ref_cnt <= ref_cnt_d;
            ref_num <= ref_num_d;
            cmd_q   <= cmd_d;
            cke_q   <= cke_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            req_q   <= req_d;
            miss_q  <= miss_d;
        end
    end

    // cnt holds cycles elapsed since the last command; a command fires when it
    // reaches the phase's wait time, so each command lasts exactly one cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ref_cnt_d = ref_cnt;
        ref_num_d = ref_num;
        cmd_d     = CMD_NOP;
        cke_d     = 1'b1;
        ba_d      = '0;
        addr_d    = '0;
        done_d    = done_q;
        req_d     = req_q;
        miss_d    = miss_q;

        case (state)
            S_WAIT: begin
                if (cnt == T_POWERUP_C) begin
                    cmd_d      = CMD_PRE;
                    addr_d[10] = 1'b1;
                    state_d    = S_PRE;
                    cnt_d      = CNT_W'(1);
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_PRE: begin
                if (cnt == T_RP_C) begin
                    cmd_d     = CMD_REF;
                    ref_num_d = NUM_W'(1);
                    state_d   = S_REF;
                    cnt_d     = CNT_W'(1);
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_REF: begin
                if (cnt == T_RFC_C) begin
                    if (ref_num == NUM_REF_C) begin
                        cmd_d   = CMD_LMR;
                        addr_d  = MODE_REG;
                        state_d = S_LMR;
                    end else begin
                        cmd_d     = CMD_REF;
                        ref_num_d = ref_num + NUM_W'(1);
                    end
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_LMR: begin
                if (cnt == T_MRD_C) begin
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    ref_cnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                // A wrap always (re)raises the request; an ack on the wrap cycle
                // is consumed by the new request rather than counted as a miss.
                if (ref_cnt == REF_LAST_C) begin
                    ref_cnt_d = '0;
                    req_d     = 1'b1;
                    if (req_q && !ref_ack) begin
                        miss_d = 1'b1;
                    end
                end else begin
                    ref_cnt_d = ref_cnt + CNT_W'(1);
                    if (req_q && ref_ack) begin
                        req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign sdr_cke   = cke_q;
    assign sdr_cs_n  = cmd_q[3];
    assign sdr_ras_n = cmd_q[2];
    assign sdr_cas_n = cmd_q[1];
    assign sdr_we_n  = cmd_q[0];
    assign sdr_ba    = ba_q;
    assign sdr_addr  = addr_q;
    assign init_done = done_q;
    assign ref_req   = req_q;
    assign ref_miss  = miss_q;

endmodule
